// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART timing constants, receiver state encoding and vote helper
package uart_pkg;

  localparam int UART_BIT_CYCLES_115200  = 87;
  localparam int UART_HALF_CYCLES_115200 = 43;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } rx_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchronizer for an asynchronous input, reset level selectable
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic nrst_i,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      s1_q <= RESET_VAL;
      s2_q <= RESET_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/uart_rx_10mhz_115200.sv
// rtl/uart_rx_10mhz_115200.sv - 8N1 receiver at 115200 baud on clk10mhz, mid-bit sampling.
// Define UART_RX_MAJORITY_EN to vote each sample over the last three cycles of its bit.
module uart_rx_10mhz_115200
  import uart_pkg::*;
#(
  parameter int BIT_CYCLES  = UART_BIT_CYCLES_115200,
  parameter int HALF_CYCLES = UART_HALF_CYCLES_115200
) (
  input  logic       clk10mhz,
  input  logic       nRst,
  input  logic       rxd,
  output logic [7:0] rxData,
  output logic       rxValid,
  output logic       rxFrameErr,
  output logic       rxBusy
);

  localparam logic [6:0] CNT_BIT  = 7'(BIT_CYCLES - 1);
  localparam logic [6:0] CNT_HALF = 7'(HALF_CYCLES - 1);

  logic      rx_s;
  logic      sample;
  rx_state_e state_q, state_d;
  logic [6:0] cnt_q, cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic      valid_q, valid_d;
  logic      ferr_q, ferr_d;

  uart_sync2 #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk_i (clk10mhz),
    .nrst_i(nRst),
    .d_i   (rxd),
    .q_o   (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // History holds rxS from cnt==2 and cnt==1; the vote closes at cnt==0.
  logic [1:0] hist_q, hist_d;

  always_comb begin
    hist_d = hist_q;
    if (cnt_q == 7'd2) hist_d[1] = rx_s;
    if (cnt_q == 7'd1) hist_d[0] = rx_s;
  end

  assign sample = majority3(hist_q[1], hist_q[0], rx_s);
`else
  assign sample = rx_s;
`endif

  always_ff @(posedge clk10mhz or negedge nRst) begin
    if (!nRst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
      hist_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_MAJORITY_EN
      hist_q    <= hist_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = CNT_HALF;
        end
      end

      START: begin
        if (cnt_q != 7'd0) begin
          cnt_d = cnt_q - 7'd1;
        end else if (!sample) begin
          state_d   = DATA;
          cnt_d     = CNT_BIT;
          bit_idx_d = 3'd0;
        end else begin
          state_d = IDLE;
        end
      end

      DATA: begin
        if (cnt_q != 7'd0) begin
          cnt_d = cnt_q - 7'd1;
        end else begin
          shift_d = {sample, shift_q[7:1]};
          cnt_d   = CNT_BIT;
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end

      // Leaving mid-stop-bit lets a zero-gap follow-on start edge be caught.
      STOP: begin
        if (cnt_q != 7'd0) begin
          cnt_d = cnt_q - 7'd1;
        end else if (sample) begin
          data_d  = shift_q;
          valid_d = 1'b1;
          state_d = IDLE;
        end else begin
          ferr_d  = 1'b1;
          state_d = BRK;
        end
      end

      BRK: begin
        if (rx_s) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign rxData     = data_q;
  assign rxValid    = valid_q;
  assign rxFrameErr = ferr_q;
  assign rxBusy     = (state_q != IDLE);

endmodule
